concat_nseg_rdma: RTL and testbench



---
 rtl/concat_nseg_rdma_if.sv | 11 +
 rtl/concat_nseg_rdma.sv | 174 +++++++++++++++++
 tb/tb_concat_nseg_rdma.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/concat_nseg_rdma_if.sv
// Read-request command channel: valid/ready handshake carrying {len, base, offset}.
interface concat_nseg_rdma_if #(
  parameter int unsigned BURST_LOG2 = 4
);
  logic                    rd_req_vld;
  logic                    rd_req_rdy;
  logic [BURST_LOG2+63:0]  rd_req_pd;

  modport master (output rd_req_vld, output rd_req_pd, input rd_req_rdy);
  modport slave  (input rd_req_vld, input rd_req_pd, output rd_req_rdy);
endinterface

// File: rtl/concat_nseg_rdma.sv
// Multi-segment read DMA command generator: walks channel groups x segments x bursts.
// Optional CONCAT_RDMA_STALL_CNT_EN adds a saturating stall_cnt output.
module concat_nseg_rdma #(
  parameter int unsigned NUM_SEG     = 2,
  parameter int unsigned BURST_LOG2  = 4,
  parameter int unsigned W_W         = 10,
  parameter int unsigned CH_W        = 8,
  parameter int unsigned TOKEN_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [NUM_SEG*32-1:0]  seg_base_addr,
  input  logic [NUM_SEG*26-1:0]  seg_surface_stride,
  input  logic [NUM_SEG*W_W-1:0] seg_w,
  input  logic [CH_W-1:0]        ch_div_tout,
  concat_nseg_rdma_if.master     rd_req
`ifdef CONCAT_RDMA_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned SEG_W      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int unsigned BURST      = 1 << BURST_LOG2;
  localparam logic [31:0] BEAT_BYTES = 32'(BURST * TOKEN_BYTES);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]      base_q   [NUM_SEG];
  logic [25:0]      stride_q [NUM_SEG];
  logic [W_W-1:0]   w_q      [NUM_SEG];
  logic [31:0]      ch_off   [NUM_SEG];
  logic [CH_W-1:0]  ch_div_q;
  logic [CH_W-1:0]  ch_cnt;
  logic [SEG_W-1:0] seg;
  logic [W_W-1:0]   rem;
  logic [31:0]      burst_off;

  logic             vld;
  logic             hs;
  logic             last_burst;
  logic             ch_last;
  logic [W_W-1:0]   rem_m1;
  logic [SEG_W-1:0] first_nz;
  logic             any_nz;
  logic [SEG_W-1:0] nxt_seg;
  logic             nxt_ok;

  assign hs         = vld & rd_req.rd_req_rdy;
  assign last_burst = (32'(rem) <= BURST);
  assign rem_m1     = rem - 1'b1;
  assign ch_last    = ((CH_W+1)'(ch_cnt) + 1'b1) >= (CH_W+1)'(ch_div_q);

  // Next-segment lookahead lets a segment boundary hand off without a SCAN bubble.
  always_comb begin
    first_nz = '0;
    any_nz   = 1'b0;
    nxt_seg  = '0;
    nxt_ok   = 1'b0;
    for (int unsigned s = 0; s < NUM_SEG; s++) begin
      if (w_q[s] != '0 && !any_nz) begin
        first_nz = SEG_W'(s);
        any_nz   = 1'b1;
      end
      if (w_q[s] != '0 && s > 32'(seg) && !nxt_ok) begin
        nxt_seg = SEG_W'(s);
        nxt_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    vld     = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SCAN;
      SCAN: begin
        busy    = 1'b1;
        state_d = (any_nz && ch_div_q != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        busy = 1'b1;
        vld  = 1'b1;
        if (hs && last_burst && !nxt_ok && ch_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_req.rd_req_vld = vld;
  assign rd_req.rd_req_pd  = vld ? {(last_burst ? BURST_LOG2'(rem_m1) : {BURST_LOG2{1'b1}}),
                                    base_q[seg], ch_off[seg] + burst_off} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SEG; s++) begin
        base_q[s]   <= '0;
        stride_q[s] <= '0;
        w_q[s]      <= '0;
        ch_off[s]   <= '0;
      end
      ch_div_q  <= '0;
      ch_cnt    <= '0;
      seg       <= '0;
      rem       <= '0;
      burst_off <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          for (int unsigned s = 0; s < NUM_SEG; s++) begin
            base_q[s]   <= seg_base_addr[s*32 +: 32];
            stride_q[s] <= seg_surface_stride[s*26 +: 26];
            w_q[s]      <= seg_w[s*W_W +: W_W];
            ch_off[s]   <= '0;
          end
          ch_div_q  <= ch_div_tout;
          ch_cnt    <= '0;
          seg       <= '0;
          rem       <= '0;
          burst_off <= '0;
        end
        SCAN: begin
          seg <= first_nz;
          rem <= w_q[first_nz];
        end
        ISSUE: if (hs) begin
          if (!last_burst) begin
            rem       <= rem - W_W'(BURST);
            burst_off <= burst_off + BEAT_BYTES;
          end else begin
            burst_off <= '0;
            if (nxt_ok) begin
              seg <= nxt_seg;
              rem <= w_q[nxt_seg];
            end else if (!ch_last) begin
              // Each segment's offset accumulator steps by its own stride per group.
              ch_cnt <= ch_cnt + 1'b1;
              for (int unsigned s = 0; s < NUM_SEG; s++)
                ch_off[s] <= ch_off[s] + 32'(stride_q[s]);
              seg <= first_nz;
              rem <= w_q[first_nz];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONCAT_RDMA_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                       stall_cnt <= '0;
    else if (state_q == IDLE && start)             stall_cnt <= '0;
    else if (vld && !rd_req.rd_req_rdy && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_concat_nseg_rdma.sv
// Directed self-checking bench for concat_nseg_rdma (NUM_SEG=2, BURST_LOG2=4).
module tb_concat_nseg_rdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [63:0] base = '0;
  logic [51:0] stride = '0;
  logic [19:0] w = '0;
  logic [7:0]  ch = '0;
`ifdef CONCAT_RDMA_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int fv;
  logic [67:0] got[$];
  logic [67:0] exp[$];
  logic        stalled = 1'b0;
  logic [67:0] prev_pd = '0;

  concat_nseg_rdma_if #(.BURST_LOG2(4)) rd_req ();

  concat_nseg_rdma #(
    .NUM_SEG(2), .BURST_LOG2(4), .W_W(10), .CH_W(8), .TOKEN_BYTES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .seg_base_addr(base), .seg_surface_stride(stride), .seg_w(w),
    .ch_div_tout(ch), .rd_req(rd_req.master)
`ifdef CONCAT_RDMA_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Command monitor: records accepted commands and checks pd holds under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (rd_req.rd_req_pd !== prev_pd || rd_req.rd_req_vld !== 1'b1) begin
          failures++;
          $display("FAIL pd_hold: got vld=%b pd=%h required vld=1 pd=%h",
                   rd_req.rd_req_vld, rd_req.rd_req_pd, prev_pd);
        end
      end
      if (rd_req.rd_req_vld && rd_req.rd_req_rdy) got.push_back(rd_req.rd_req_pd);
      stalled = rd_req.rd_req_vld && !rd_req.rd_req_rdy;
      prev_pd = rd_req.rd_req_pd;
    end
  end

  function automatic logic [67:0] mk(input logic [3:0] l, input logic [31:0] b, input logic [31:0] o);
    return {l, b, o};
  endfunction

  task automatic cfg_basic();
    base = {32'h2000_0000, 32'h1000_0000};
    stride = {26'h2000, 26'h100};
    w = {10'd40, 10'd1};
    ch = 8'd2;
    exp.delete();
    exp.push_back(mk(4'd0,  32'h1000_0000, 32'h0));
    exp.push_back(mk(4'd15, 32'h2000_0000, 32'h0));
    exp.push_back(mk(4'd15, 32'h2000_0000, 32'h400));
    exp.push_back(mk(4'd7,  32'h2000_0000, 32'h800));
    exp.push_back(mk(4'd0,  32'h1000_0000, 32'h100));
    exp.push_back(mk(4'd15, 32'h2000_0000, 32'h2000));
    exp.push_back(mk(4'd15, 32'h2000_0000, 32'h2400));
    exp.push_back(mk(4'd7,  32'h2000_0000, 32'h2800));
  endtask

  // mode 0: rdy=1; 1: random rdy, config scrambled mid-job; 2: rdy low for first 5 issue cycles.
  task automatic run_job(input int mode, input bit poke, output int kd);
    got.delete();
    fv = -1;
    rd_req.rd_req_rdy = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = poke;
    kd = 0;
    while (!done && kd < 400) begin
      @(posedge clk); #1;
      kd++;
      start = 1'b0;
      case (mode)
        1: begin
          rd_req.rd_req_rdy = 1'($urandom_range(0, 1));
          base = 64'($urandom()); stride = 52'($urandom()); w = 20'($urandom()); ch = 8'($urandom());
        end
        2: rd_req.rd_req_rdy = !(kd >= 1 && kd <= 5);
        default: rd_req.rd_req_rdy = 1'b1;
      endcase
      if (rd_req.rd_req_vld && fv < 0) fv = kd;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: got done=0 after %0d cycles required done=1", kd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_req.rd_req_vld} !== 3'b000 || rd_req.rd_req_pd !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b vld=%b pd=%h required 0 0 0 0",
               busy, done, rd_req.rd_req_vld, rd_req.rd_req_pd);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int kd;
    cfg_basic();
    run_job(0, 1'b0, kd);
    checks++;
    if (fv !== 1) begin
      failures++;
      $display("FAIL first_vld_latency: got %0d required 1", fv);
    end
    checks++;
    if (kd !== 9) begin
      failures++;
      $display("FAIL done_latency: got %0d required 9", kd);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_with_done: got %b required 0", busy);
    end
    checks++;
    if (got.size() !== 8) begin
      failures++;
      $display("FAIL basic_count: got %0d required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_cmd%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: got %b required 0", done);
    end
  endtask

  task automatic test_backpressure();
    int kd;
    cfg_basic();
    run_job(1, 1'b0, kd);
    checks++;
    if (got.size() !== 8) begin
      failures++;
      $display("FAIL bp_count: got %0d required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL bp_cmd%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_skip();
    int kd;
    base = {32'h3000_0000, 32'h1111_0000};
    stride = {26'h40, 26'h999};
    w = {10'd16, 10'd0};
    ch = 8'd3;
    run_job(0, 1'b0, kd);
    checks++;
    if (got.size() !== 3 || kd !== 4) begin
      failures++;
      $display("FAIL skip_count: got %0d cmds done_k=%0d required 3 cmds done_k=4", got.size(), kd);
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== mk(4'd15, 32'h3000_0000, 32'(i * 32'h40))) begin
        failures++;
        $display("FAIL skip_cmd%0d: got %h required %h", i, got[i],
                 mk(4'd15, 32'h3000_0000, 32'(i * 32'h40)));
      end
    end
  endtask

  task automatic test_zero();
    int kd;
    int extra;
    w = '0;
    ch = 8'd2;
    run_job(0, 1'b1, kd);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (kd !== 1 || got.size() !== 0 || extra !== 0) begin
      failures++;
      $display("FAIL zero_w: got done_k=%0d cmds=%0d late_activity=%0d required 1 0 0", kd, got.size(), extra);
    end
    w = {10'd5, 10'd3};
    ch = 8'd0;
    run_job(0, 1'b0, kd);
    checks++;
    if (kd !== 1 || got.size() !== 0) begin
      failures++;
      $display("FAIL zero_ch: got done_k=%0d cmds=%0d required 1 0", kd, got.size());
    end
  endtask

  task automatic test_rst_mid();
    int kd;
    int seen;
    cfg_basic();
    got.delete();
    rd_req.rd_req_rdy = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_req.rd_req_vld !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_vld: got %b required 1", rd_req.rd_req_vld);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_req.rd_req_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_abort: got vld=%b busy=%b required 0 0", rd_req.rd_req_vld, busy);
    end
    rst = 1'b0;
    rd_req.rd_req_rdy = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0 || got.size() !== 0) begin
      failures++;
      $display("FAIL rst_no_done: got done_pulses=%0d cmds=%0d required 0 0", seen, got.size());
    end
    run_job(0, 1'b0, kd);
    checks++;
    if (got.size() !== 8) begin
      failures++;
      $display("FAIL rst_rerun_count: got %0d required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL rst_rerun_cmd%0d: got %h required %h", i, got[i], exp[i]);
      end
    end
  endtask

`ifdef CONCAT_RDMA_STALL_CNT_EN
  task automatic test_stall_cnt();
    int kd;
    cfg_basic();
    run_job(2, 1'b0, kd);
    checks++;
    if (stall_cnt !== 32'd5 || got.size() !== 8) begin
      failures++;
      $display("FAIL stall_cnt: got %0d cmds=%0d required 5 cmds=8", stall_cnt, got.size());
    end
  endtask
`endif

  initial begin
    rd_req.rd_req_rdy = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_skip();
    test_zero();
    test_rst_mid();
`ifdef CONCAT_RDMA_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
